err_compute: RTL and testbench

- Producer side of the err_sat/err_vld interface consumed by the PID I/P/D terms.
- Sequences the line-sensor A2D through NUM_CHNL channels and forms a signed, weighted position error from the readings.
- Saturates the error to 11 bits and emits one err_vld pulse per completed frame.
- Also produces line_present: a frame is "on line" when the unweighted sum of the readings reaches LINE_THRES.

---
 rtl/err_pkg.sv | 26 ++
 rtl/err_saturate.sv | 35 +++
 rtl/err_compute.sv | 136 +++++++++++++
 tb/tb_err_compute.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/err_pkg.sv
// ----------------------------------------------------------------------------
// err_pkg
// Shared types and constants for the line-sensor error path: the sequencer
// state encoding, datapath widths and the per-channel position weights.
// No ports (package).
// ----------------------------------------------------------------------------
package err_pkg;

    localparam int ERR_W = 11;   // saturated error width
    localparam int ACC_W = 17;   // weighted accumulator width (signed)
    localparam int SUM_W = 15;   // unweighted sum width (unsigned)

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        DONE
    } state_t;

    // Outer sensors pull hardest; left half positive, right half negative.
    // Every magnitude is a power of two so the product reduces to a shift.
    localparam logic signed [4:0] WEIGHT [8] = '{
        5'sd8, 5'sd4, 5'sd2, 5'sd1, -5'sd1, -5'sd2, -5'sd4, -5'sd8
    };

endpackage

// File: rtl/err_saturate.sv
// ----------------------------------------------------------------------------
// err_saturate
// Arithmetic right shift of a signed accumulator followed by a clamp to the
// ERR_W-bit signed range. Purely combinational; reusable by the P/D terms.
// Ports:
//   acc  in   ACC_W signed  accumulator value
//   err  out  ERR_W signed  (acc >>> SHIFT) clamped to [-2^(ERR_W-1), 2^(ERR_W-1)-1]
// ----------------------------------------------------------------------------
module err_saturate
    import err_pkg::*;
#(
    parameter int SHIFT = 4
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [ERR_W-1:0] err
);

    localparam logic signed [ACC_W-1:0] ERR_MAX = ACC_W'((1 <<< (ERR_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] ERR_MIN = ACC_W'(-(1 <<< (ERR_W-1)));

    // >>> on a signed operand floors toward minus infinity.
    function automatic logic signed [ERR_W-1:0] shift_sat(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] shifted;
        shifted = v >>> SHIFT;
        if (shifted > ERR_MAX)
            return ERR_MAX[ERR_W-1:0];
        else if (shifted < ERR_MIN)
            return ERR_MIN[ERR_W-1:0];
        else
            return shifted[ERR_W-1:0];
    endfunction

    assign err = shift_sat(acc);

endmodule

// File: rtl/err_compute.sv
// ----------------------------------------------------------------------------
// err_compute
// Sequences the line-sensor A2D over NUM_CHNL channels, accumulates a
// weighted position error and an unweighted intensity sum, and publishes a
// saturated error plus line_present once per completed frame.
// Ports:
//   clk           in   1      system clock
//   rst_n         in   1      asynchronous active-low reset
//   go            in   1      frames start only while high
//   strt_cnv      out  1      one-cycle conversion request
//   chnnl         out  3      channel under conversion, held until cnv_cmplt
//   cnv_cmplt     in   1      conversion done; res valid this cycle
//   res           in   RES_W  unsigned conversion result
//   err_sat       out  11     signed saturated error, held between frames
//   err_vld       out  1      one-cycle pulse when err_sat/line_present update
//   line_present  out  1      frame sum reached LINE_THRES
// ----------------------------------------------------------------------------
module err_compute
    import err_pkg::*;
#(
    parameter int               NUM_CHNL   = 8,
    parameter int               RES_W      = 12,
    parameter int               ERR_SHIFT  = 4,
    parameter logic [SUM_W-1:0] LINE_THRES = 15'd64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    go,
    output logic                    strt_cnv,
    output logic [2:0]              chnnl,
    input  logic                    cnv_cmplt,
    input  logic [RES_W-1:0]        res,
    output logic signed [ERR_W-1:0] err_sat,
    output logic                    err_vld,
    output logic                    line_present
);

    localparam logic [2:0] LAST_CH = 3'(NUM_CHNL - 1);

    state_t                  state;
    state_t                  nxt_state;
    logic signed [ACC_W-1:0] weighted;
    logic signed [ACC_W-1:0] weighted_nxt;
    logic        [SUM_W-1:0] sum;
    logic        [SUM_W-1:0] sum_nxt;
    logic signed [ERR_W-1:0] err_sat_nxt;

    // weight(ch) * r using only shifts and a conditional negate.
    function automatic logic signed [ACC_W-1:0] weight_term(input logic [2:0] ch,
                                                            input logic [RES_W-1:0] r);
        logic signed [4:0]       w;
        logic signed [4:0]       mag;
        logic signed [ACC_W-1:0] r_ext;
        logic signed [ACC_W-1:0] prod;
        w     = WEIGHT[ch];
        mag   = (w < 0) ? -w : w;
        r_ext = ACC_W'(r);
        case (mag)
            5'sd8:   prod = r_ext <<< 3;
            5'sd4:   prod = r_ext <<< 2;
            5'sd2:   prod = r_ext <<< 1;
            default: prod = r_ext;
        endcase
        return (w < 0) ? -prod : prod;
    endfunction

    assign weighted_nxt = weighted + weight_term(chnnl, res);
    assign sum_nxt      = sum + SUM_W'(res);

    // The clamp looks at the total including the last channel so err_sat is
    // already valid in the DONE cycle, alongside err_vld.
    err_saturate #(
        .SHIFT (ERR_SHIFT)
    ) u_sat (
        .acc (weighted_nxt),
        .err (err_sat_nxt)
    );

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:  if (go) nxt_state = START;
            START: nxt_state = WAIT;
            WAIT: begin
                // The A2D cannot be aborted: stay here until it reports back,
                // even if go has fallen.
                if (cnv_cmplt) begin
                    if (chnnl == LAST_CH) nxt_state = DONE;
                    else if (go)          nxt_state = START;
                    else                  nxt_state = IDLE;
                end
            end
            DONE:  nxt_state = go ? START : IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            strt_cnv     <= 1'b0;
            err_vld      <= 1'b0;
            chnnl        <= 3'd0;
            weighted     <= '0;
            sum          <= '0;
            err_sat      <= '0;
            line_present <= 1'b0;
        end else begin
            state    <= nxt_state;
            // Registered decodes of the next state: high exactly while in START/DONE.
            strt_cnv <= (nxt_state == START);
            err_vld  <= (nxt_state == DONE);
            case (state)
                IDLE, DONE: begin
                    weighted <= '0;
                    sum      <= '0;
                    if (go) chnnl <= 3'd0;
                end
                WAIT: begin
                    if (cnv_cmplt) begin
                        weighted <= weighted_nxt;
                        sum      <= sum_nxt;
                        if (chnnl == LAST_CH) begin
                            err_sat      <= err_sat_nxt;
                            line_present <= (sum_nxt >= LINE_THRES);
                        end else if (go) begin
                            chnnl <= chnnl + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_err_compute.sv
// ----------------------------------------------------------------------------
// tb_err_compute
// Directed bench for err_compute with a behavioural A2D responder and a
// scoreboard of expected frame results.
// ----------------------------------------------------------------------------
module tb_err_compute;

    logic        clk;
    logic        rst_n;
    logic        go;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic [10:0] err_sat;
    logic        err_vld;
    logic        line_present;

    err_compute dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .go           (go),
        .strt_cnv     (strt_cnv),
        .chnnl        (chnnl),
        .cnv_cmplt    (cnv_cmplt),
        .res          (res),
        .err_sat      (err_sat),
        .err_vld      (err_vld),
        .line_present (line_present)
    );

    typedef struct {
        logic [10:0] err;
        logic        lp;
    } exp_t;

    exp_t        sb[$];
    logic [11:0] chan_res [8];
    int          wt [8] = '{8, 4, 2, 1, -1, -2, -4, -8};
    int          a2d_extra = 0;
    int          n_vec  = 0;
    int          n_miss = 0;
    int          cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference result for the current chan_res contents.
    function automatic exp_t model();
        exp_t e;
        int   acc = 0;
        int   s   = 0;
        int   sh;
        for (int i = 0; i < 8; i++) begin
            acc += wt[i] * int'(chan_res[i]);
            s   += int'(chan_res[i]);
        end
        sh = acc >>> 4;
        if (sh > 1023)       sh = 1023;
        else if (sh < -1024) sh = -1024;
        e.err = sh[10:0];
        e.lp  = (s >= 64);
        return e;
    endfunction

    task automatic set_all(input logic [11:0] v);
        for (int i = 0; i < 8; i++) chan_res[i] = v;
    endtask

    // Run go high until n err_vld pulses are seen, dropping go in the last DONE.
    task automatic wait_frames(input int n, input bit chk_period);
        int got    = 0;
        int budget = n * 60 + 50;
        int prev   = -1;
        while (got < n && budget > 0) begin
            tick();
            budget--;
            if (err_vld === 1'b1) begin
                got++;
                if (chk_period && prev >= 0) check("frame_period", 32'(cyc - prev), 32'd17);
                prev = cyc;
                if (got == n) go = 1'b0;
            end
        end
        go = 1'b0;
        check("frames_done", 32'(got), 32'(n));
        repeat (3) tick();
    endtask

    task automatic one_frame();
        sb.push_back(model());
        go = 1'b1;
        wait_frames(1, 1'b0);
    endtask

    // Run until the conversion request for channel ch is seen.
    task automatic wait_strt_ch(input logic [2:0] ch);
        int budget = 200;
        bit found  = 1'b0;
        while (!found && budget > 0) begin
            tick();
            budget--;
            if (strt_cnv === 1'b1 && chnnl === ch) found = 1'b1;
        end
        check("strt_seen", 32'(found), 32'd1);
    endtask

    // A2D model: result returned 1+a2d_extra cycles after the request.
    initial begin
        logic [2:0] cur_ch;
        bit         rst_hit;
        cnv_cmplt = 1'b0;
        res       = '0;
        forever begin
            @(negedge clk);
            cnv_cmplt = 1'b0;
            if (strt_cnv === 1'b1) begin
                cur_ch  = chnnl;
                rst_hit = 1'b0;
                for (int k = 0; k < 1 + a2d_extra; k++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) rst_hit = 1'b1;
                    if (!rst_hit) begin
                        check("chnnl_stable", 32'(chnnl), 32'(cur_ch));
                        check("no_strt_busy", 32'(strt_cnv), 32'd0);
                    end
                end
                res       = chan_res[cur_ch];
                cnv_cmplt = 1'b1;
            end
        end
    end

    // Scoreboard consumer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (err_vld === 1'b1) begin
                check("vld_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("err_sat", 32'(err_sat), 32'(e.err));
                    check("line_present", 32'(line_present), 32'(e.lp));
                end
            end
        end
    end

    initial begin
        int n_strt;
        int n_vld;
        bit seen;
        rst_n = 1'b0;
        go    = 1'b0;
        set_all(12'h000);

        // Reset state
        repeat (3) tick();
        check("rst_err_sat", 32'(err_sat), 32'd0);
        check("rst_err_vld", 32'(err_vld), 32'd0);
        check("rst_line", 32'(line_present), 32'd0);
        check("rst_strt", 32'(strt_cnv), 32'd0);
        check("rst_chnnl", 32'(chnnl), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // All zero, back-to-back frames with zero-delay A2D
        a2d_extra = 0;
        set_all(12'h000);
        for (int i = 0; i < 3; i++) sb.push_back(model());
        go = 1'b1;
        wait_frames(3, 1'b1);

        // Single-channel and saturation patterns
        set_all(12'h000); chan_res[0] = 12'h100; one_frame();
        set_all(12'h000); chan_res[0] = 12'hFFF; one_frame();
        set_all(12'h000); chan_res[7] = 12'hFFF; one_frame();
        set_all(12'h000); chan_res[3] = 12'h200; chan_res[4] = 12'h200; one_frame();

        // line_present threshold edge
        set_all(12'h007); one_frame();
        set_all(12'h008); one_frame();

        // Mixed values with varying A2D latency
        for (int f = 0; f < 4; f++) begin
            a2d_extra = f;
            for (int i = 0; i < 8; i++) chan_res[i] = 12'($urandom_range(0, 4095));
            one_frame();
        end

        // go dropped during channel-4 WAIT
        a2d_extra = 0;
        set_all(12'h000); chan_res[0] = 12'h100; one_frame();
        a2d_extra = 3;
        set_all(12'h050);
        go = 1'b1;
        wait_strt_ch(3'd4);
        tick();
        go = 1'b0;
        n_strt = 0; n_vld = 0;
        repeat (12) begin
            tick();
            if (strt_cnv === 1'b1) n_strt++;
            if (err_vld === 1'b1)  n_vld++;
        end
        check("drop_no_strt", 32'(n_strt), 32'd0);
        check("drop_no_vld", 32'(n_vld), 32'd0);
        check("drop_err_hold", 32'(err_sat), 32'd128);
        check("drop_line_hold", 32'(line_present), 32'd1);
        set_all(12'h000); chan_res[7] = 12'hFFF;
        sb.push_back(model());
        go = 1'b1;
        wait_strt_ch(3'd0);
        check("restart_chnnl", 32'(chnnl), 32'd0);
        wait_frames(1, 1'b0);

        // Asynchronous reset during channel-5 WAIT
        set_all(12'h0A0);
        go = 1'b1;
        wait_strt_ch(3'd5);
        tick();
        rst_n = 1'b0;
        go    = 1'b0;
        #1;
        check("arst_err_sat", 32'(err_sat), 32'd0);
        check("arst_line", 32'(line_present), 32'd0);
        check("arst_vld", 32'(err_vld), 32'd0);
        check("arst_strt", 32'(strt_cnv), 32'd0);
        check("arst_chnnl", 32'(chnnl), 32'd0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (cnv_cmplt === 1'b1) seen = 1'b1;
        end
        check("late_cmplt_seen", 32'(seen), 32'd1);
        n_strt = 0; n_vld = 0;
        repeat (5) begin
            tick();
            if (strt_cnv === 1'b1) n_strt++;
            if (err_vld === 1'b1)  n_vld++;
        end
        check("late_no_strt", 32'(n_strt), 32'd0);
        check("late_no_vld", 32'(n_vld), 32'd0);
        check("late_chnnl", 32'(chnnl), 32'd0);

        // Fresh frame after reset
        a2d_extra = 1;
        set_all(12'h000); chan_res[0] = 12'h010; chan_res[7] = 12'h300;
        one_frame();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
